// File: rtl/cpu_load_store_unit_if.sv
// Request/response bus between the load/store unit and the memory controller.
// The LSU drives the request side; the controller answers with stall, ack and extended load data.
interface cpu_load_store_unit_if;
    logic        o_wb_stb;
    logic        o_wb_we;
    logic [31:0] o_wb_addr;
    logic [2:0]  o_sel;
    logic [31:0] o_wb_wdata;
    logic        i_wb_stall;
    logic        i_wb_ack;
    logic [31:0] i_wb_data;

    modport master (
        output o_wb_stb, o_wb_we, o_wb_addr, o_sel, o_wb_wdata,
        input  i_wb_stall, i_wb_ack, i_wb_data
    );

    modport slave (
        input  o_wb_stb, o_wb_we, o_wb_addr, o_sel, o_wb_wdata,
        output i_wb_stall, i_wb_ack, i_wb_data
    );
endinterface

// File: rtl/cpu_load_store_unit.sv
// Load/store unit: effective address, legality and alignment checks, one bus
// request per micro-op, bus-timeout watchdog and RISC-V exception reporting.
module cpu_load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_req,
    input  logic                      i_we,
    input  logic [2:0]                i_funct3,
    input  logic [31:0]               i_base,
    input  logic [11:0]               i_imm,
    input  logic [31:0]               i_store_data,
    output logic                      o_busy,
    output logic                      o_done,
    output logic [31:0]               o_rdata,
    output logic                      o_exc_valid,
    output logic [3:0]                o_exc_code,
    output logic [31:0]               o_bad_addr,
    cpu_load_store_unit_if.master     wb
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

    localparam logic [3:0] EXC_ILLEGAL     = 4'd2;
    localparam logic [3:0] EXC_LOAD_MISAL  = 4'd4;
    localparam logic [3:0] EXC_LOAD_FAULT  = 4'd5;
    localparam logic [3:0] EXC_STORE_MISAL = 4'd6;
    localparam logic [3:0] EXC_STORE_FAULT = 4'd7;

    logic [1:0]  state;
    logic [15:0] wd_cnt;
    logic [31:0] eff_addr;
    logic        illegal;
    logic        misaligned;
    logic [31:0] lane_data;

    assign eff_addr = i_base + {{20{i_imm[11]}}, i_imm};

    // Halfwords fault only when they straddle a word boundary; words need natural alignment.
    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        lane_data  = i_store_data;
        unique case (i_funct3)
            3'b000: lane_data = {4{i_store_data[7:0]}};
            3'b001: begin
                lane_data  = {2{i_store_data[15:0]}};
                misaligned = (eff_addr[1:0] == 2'b11);
            end
            3'b010: misaligned = (eff_addr[1:0] != 2'b00);
            3'b100: illegal = i_we;
            3'b101: begin
                illegal    = i_we;
                misaligned = (eff_addr[1:0] == 2'b11);
            end
            default: illegal = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state          <= IDLE;
            wd_cnt         <= '0;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
            o_rdata        <= '0;
            o_exc_valid    <= 1'b0;
            o_exc_code     <= '0;
            o_bad_addr     <= '0;
            wb.o_wb_stb    <= 1'b0;
            wb.o_wb_we     <= 1'b0;
            wb.o_wb_addr   <= '0;
            wb.o_sel       <= '0;
            wb.o_wb_wdata  <= '0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_req) begin
                        wb.o_wb_addr  <= eff_addr;
                        wb.o_sel      <= i_funct3;
                        wb.o_wb_we    <= i_we;
                        wb.o_wb_wdata <= lane_data;
                        o_busy        <= 1'b1;
                        if (illegal || misaligned) begin
                            o_bad_addr  <= eff_addr;
                            o_exc_code  <= illegal ? EXC_ILLEGAL :
                                           (i_we ? EXC_STORE_MISAL : EXC_LOAD_MISAL);
                            o_exc_valid <= 1'b1;
                            o_done      <= 1'b1;
                            state       <= DONE;
                        end else begin
                            wb.o_wb_stb <= 1'b1;
                            state       <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (!wb.i_wb_stall) begin
                        wb.o_wb_stb <= 1'b0;
                        wd_cnt      <= '0;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    // An ack on the terminal count still completes the op normally.
                    if (wb.i_wb_ack) begin
                        if (!wb.o_wb_we) begin
                            o_rdata <= wb.i_wb_data;
                        end
                        o_done <= 1'b1;
                        state  <= DONE;
                    end else if (wd_cnt == WD_LAST) begin
                        o_exc_code  <= wb.o_wb_we ? EXC_STORE_FAULT : EXC_LOAD_FAULT;
                        o_bad_addr  <= wb.o_wb_addr;
                        o_exc_valid <= 1'b1;
                        o_done      <= 1'b1;
                        state       <= DONE;
                    end else begin
                        wd_cnt <= wd_cnt + 16'd1;
                    end
                end
                DONE: begin
                    o_busy      <= 1'b0;
                    o_exc_valid <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
